heart_collision: RTL and testbench

- Downstream consumer of the Bullet stage.
- Compares the two rendered bullets (position/size/color/isRender) against the player heart hitbox every cycle.
- Applies damage or heal to a saturating HP register, with an invincibility window after each damage hit.
- Returns a one-cycle isCollide pulse that the Bullet stage uses to retire or respawn the bullet.

---
 rtl/heart_collision.sv | 138 +++++++++++++
 tb/tb_heart_collision.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heart_collision.sv
// Heart hitbox collision stage: overlap test of two bullets against the heart, then a
// registered damage/heal stage driving a saturating HP register with an invincibility window.
module heart_collision #(
    parameter int unsigned MAX_HP     = 20,
    parameter int unsigned DAMAGE     = 4,
    parameter int unsigned HEAL       = 2,
    parameter int unsigned INV_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        isRun,
    input  logic [15:0] heartPos,
    input  logic [15:0] heartSize,
    input  logic        heartMoving,
    input  logic [15:0] position1,
    input  logic [15:0] size1,
    input  logic [2:0]  color1,
    input  logic        isRender1,
    input  logic [15:0] position2,
    input  logic [15:0] size2,
    input  logic [2:0]  color2,
    input  logic        isRender2,
    output logic        isCollide,
    output logic [7:0]  hp,
    output logic        isInvincible,
    output logic        isDead
);

    localparam logic [7:0]  MaxHpV  = 8'(MAX_HP);
    localparam logic [7:0]  DamageV = 8'(DAMAGE);
    localparam logic [7:0]  HealV   = 8'(HEAL);
    localparam logic [15:0] InvLoad = 16'(INV_CYCLES);

    localparam logic [2:0] ColGreen = 3'b001;
    localparam logic [2:0] ColBlue  = 3'b010;

    // Sums are taken at 9 bits so boxes touching the 255 edge never wrap.
    function automatic logic overlap(input logic [15:0] b_pos, input logic [15:0] b_size,
                                     input logic [15:0] h_pos, input logic [15:0] h_size,
                                     input logic render);
        logic [8:0] bx, by, bw, bh, hx, hy, hw, hh;
        logic       nonzero;
        bx = {1'b0, b_pos[15:8]};
        by = {1'b0, b_pos[7:0]};
        bw = {1'b0, b_size[15:8]};
        bh = {1'b0, b_size[7:0]};
        hx = {1'b0, h_pos[15:8]};
        hy = {1'b0, h_pos[7:0]};
        hw = {1'b0, h_size[15:8]};
        hh = {1'b0, h_size[7:0]};
        nonzero = (bw != 9'd0) && (bh != 9'd0) && (hw != 9'd0) && (hh != 9'd0);
        return render && nonzero && (bx < hx + hw) && (hx < bx + bw) &&
               (by < hy + hh) && (hy < by + bh);
    endfunction

    logic ovl1, ovl2;
    logic dmg1, dmg2, heal1, heal2;

    always_comb begin
        ovl1  = overlap(position1, size1, heartPos, heartSize, isRender1);
        ovl2  = overlap(position2, size2, heartPos, heartSize, isRender2);
        heal1 = (color1 == ColGreen);
        heal2 = (color2 == ColGreen);
        // Blue hurts only a moving heart; unknown codes behave as white.
        dmg1  = (color1 == ColBlue) ? heartMoving : !heal1;
        dmg2  = (color2 == ColBlue) ? heartMoving : !heal2;
    end

    logic hit1_q, hit2_q, dmg1_q, dmg2_q, heal1_q, heal2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
            dmg1_q  <= 1'b0;
            dmg2_q  <= 1'b0;
            heal1_q <= 1'b0;
            heal2_q <= 1'b0;
        end else begin
            hit1_q  <= isRun && ovl1;
            hit2_q  <= isRun && ovl2;
            dmg1_q  <= dmg1;
            dmg2_q  <= dmg2;
            heal1_q <= heal1;
            heal2_q <= heal2;
        end
    end

    logic [7:0]  hp_q;
    logic [15:0] inv_cnt_q;
    logic        collide_q, dead_q;

    logic       any_dmg, any_heal;
    logic [7:0] hp_after_dmg, hp_after_heal;
    logic [8:0] heal_sum;

    always_comb begin
        any_dmg       = (hit1_q && dmg1_q) || (hit2_q && dmg2_q);
        any_heal      = (hit1_q && heal1_q) || (hit2_q && heal2_q);
        hp_after_dmg  = (hp_q <= DamageV) ? 8'd0 : hp_q - DamageV;
        heal_sum      = {1'b0, hp_q} + {1'b0, HealV};
        hp_after_heal = (heal_sum > {1'b0, MaxHpV}) ? MaxHpV : heal_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q      <= MaxHpV;
            inv_cnt_q <= 16'd0;
            collide_q <= 1'b0;
            dead_q    <= 1'b0;
        end else if (isRun && !dead_q) begin
            if (any_dmg && (inv_cnt_q == 16'd0)) begin
                hp_q      <= hp_after_dmg;
                inv_cnt_q <= InvLoad;
                collide_q <= 1'b1;
                dead_q    <= (hp_after_dmg == 8'd0);
            end else begin
                if (inv_cnt_q != 16'd0) begin
                    inv_cnt_q <= inv_cnt_q - 16'd1;
                end
                if (any_heal) begin
                    hp_q      <= hp_after_heal;
                    collide_q <= 1'b1;
                end else begin
                    collide_q <= 1'b0;
                end
            end
        end else begin
            collide_q <= 1'b0;
        end
    end

    assign isCollide    = collide_q;
    assign hp           = hp_q;
    assign isInvincible = (inv_cnt_q != 16'd0);
    assign isDead       = dead_q;

endmodule

// File: tb/tb_heart_collision.sv
// Directed bench for heart_collision: damage, heal, invincibility, death, pause and reset.
module tb_heart_collision;

    logic        clk;
    logic        rst_n;
    logic        isRun;
    logic [15:0] heartPos;
    logic [15:0] heartSize;
    logic        heartMoving;
    logic [15:0] position1;
    logic [15:0] size1;
    logic [2:0]  color1;
    logic        isRender1;
    logic [15:0] position2;
    logic [15:0] size2;
    logic [2:0]  color2;
    logic        isRender2;
    logic        isCollide;
    logic [7:0]  hp;
    logic        isInvincible;
    logic        isDead;

    int checks = 0;
    int errors = 0;

    heart_collision #(
        .MAX_HP    (20),
        .DAMAGE    (4),
        .HEAL      (2),
        .INV_CYCLES(100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .isRun       (isRun),
        .heartPos    (heartPos),
        .heartSize   (heartSize),
        .heartMoving (heartMoving),
        .position1   (position1),
        .size1       (size1),
        .color1      (color1),
        .isRender1   (isRender1),
        .position2   (position2),
        .size2       (size2),
        .color2      (color2),
        .isRender2   (isRender2),
        .isCollide   (isCollide),
        .hp          (hp),
        .isInvincible(isInvincible),
        .isDead      (isDead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        isRun       = 1'b1;
        heartPos    = {8'd100, 8'd100};
        heartSize   = {8'd16, 8'd16};
        heartMoving = 1'b0;
        position1   = {8'd108, 8'd104};
        size1       = {8'd8, 8'd8};
        color1      = 3'b000;
        isRender1   = 1'b0;
        position2   = {8'd96, 8'd96};
        size2       = {8'd8, 8'd8};
        color2      = 3'b000;
        isRender2   = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int pulses;
        do_reset();
        checks++;
        if (hp !== 8'd20 || isCollide !== 1'b0 || isInvincible !== 1'b0 || isDead !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: hp=%0d col=%b inv=%b dead=%b, want hp=20 col=0 inv=0 dead=0",
                     hp, isCollide, isInvincible, isDead);
        end
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (isCollide === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || hp !== 8'd20) begin
            errors++;
            $display("FAIL idle_50: pulses=%0d hp=%0d, want pulses=0 hp=20", pulses, hp);
        end
    endtask

    task automatic test_single_hit();
        int inv_cnt, pulses;
        do_reset();
        isRender1 = 1'b1;
        tick(1);
        checks++;
        if (isCollide !== 1'b0) begin
            errors++;
            $display("FAIL hit_latency1: col=%b, want 0 after one edge", isCollide);
        end
        isRender1 = 1'b0;
        tick(1);
        checks++;
        if (isCollide !== 1'b1 || hp !== 8'd16 || isInvincible !== 1'b1) begin
            errors++;
            $display("FAIL hit_apply: col=%b hp=%0d inv=%b, want col=1 hp=16 inv=1",
                     isCollide, hp, isInvincible);
        end
        inv_cnt = 0;
        pulses  = 0;
        for (int i = 0; i < 120; i++) begin
            if (isInvincible === 1'b1) inv_cnt++;
            if (isCollide === 1'b1) pulses++;
            tick(1);
        end
        checks++;
        if (inv_cnt !== 100) begin
            errors++;
            $display("FAIL inv_window: inv cycles=%0d, want 100", inv_cnt);
        end
        checks++;
        if (pulses !== 1 || hp !== 8'd16) begin
            errors++;
            $display("FAIL hit_single_pulse: pulses=%0d hp=%0d, want pulses=1 hp=16", pulses, hp);
        end
    endtask

    task automatic test_held_white();
        int hit_edge[3];
        int hit_hp[3];
        int n;
        int exp_edge[3];
        int exp_hp[3];
        exp_edge = '{2, 103, 204};
        exp_hp   = '{16, 12, 8};
        n = 0;
        do_reset();
        isRender1 = 1'b1;
        for (int k = 1; k <= 250; k++) begin
            tick(1);
            if (isCollide === 1'b1) begin
                if (n < 3) begin
                    hit_edge[n] = k;
                    hit_hp[n]   = int'(hp);
                end
                n++;
            end
        end
        isRender1 = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL held_pulse_count: pulses=%0d, want 3", n);
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (hit_edge[j] !== exp_edge[j] || hit_hp[j] !== exp_hp[j]) begin
                    errors++;
                    $display("FAIL held_hit%0d: edge=%0d hp=%0d, want edge=%0d hp=%0d",
                             j, hit_edge[j], hit_hp[j], exp_edge[j], exp_hp[j]);
                end
            end
        end
    endtask

    task automatic test_dual_and_heal();
        int pulses;
        logic [7:0] exp_hp[3];
        exp_hp = '{8'd18, 8'd20, 8'd20};
        // Two white bullets in one cycle cost one DAMAGE.
        do_reset();
        position2 = {8'd100, 8'd100};
        isRender1 = 1'b1;
        isRender2 = 1'b1;
        tick(1);
        isRender1 = 1'b0;
        isRender2 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (isCollide === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1 || hp !== 8'd16) begin
            errors++;
            $display("FAIL dual_white: pulses=%0d hp=%0d, want pulses=1 hp=16", pulses, hp);
        end
        // Green + white together: damage wins, heal dropped.
        do_reset();
        color1    = 3'b001;
        isRender1 = 1'b1;
        isRender2 = 1'b1;
        tick(1);
        isRender1 = 1'b0;
        isRender2 = 1'b0;
        tick(1);
        checks++;
        if (isCollide !== 1'b1 || hp !== 8'd16) begin
            errors++;
            $display("FAIL green_plus_white: col=%b hp=%0d, want col=1 hp=16", isCollide, hp);
        end
        tick(2);
        checks++;
        if (hp !== 8'd16) begin
            errors++;
            $display("FAIL no_late_heal: hp=%0d, want 16", hp);
        end
        // Held green while invincible: heals each cycle, saturates, still pulses.
        isRender1 = 1'b1;
        tick(1);
        for (int j = 0; j < 3; j++) begin
            tick(1);
            checks++;
            if (isCollide !== 1'b1 || hp !== exp_hp[j] || isInvincible !== 1'b1) begin
                errors++;
                $display("FAIL green_heal%0d: col=%b hp=%0d inv=%b, want col=1 hp=%0d inv=1",
                         j, isCollide, hp, isInvincible, exp_hp[j]);
            end
        end
        isRender1 = 1'b0;
        tick(2);
        checks++;
        if (isCollide !== 1'b0) begin
            errors++;
            $display("FAIL green_release: col=%b, want 0", isCollide);
        end
        color1 = 3'b000;
    endtask

    task automatic test_blue();
        int pulses;
        do_reset();
        color1    = 3'b010;
        isRender1 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (isCollide === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || hp !== 8'd20) begin
            errors++;
            $display("FAIL blue_still: pulses=%0d hp=%0d, want pulses=0 hp=20", pulses, hp);
        end
        heartMoving = 1'b1;
        tick(1);
        isRender1 = 1'b0;
        tick(1);
        checks++;
        if (isCollide !== 1'b1 || hp !== 8'd16) begin
            errors++;
            $display("FAIL blue_moving: col=%b hp=%0d, want col=1 hp=16", isCollide, hp);
        end
        heartMoving = 1'b0;
        color1      = 3'b000;
    endtask

    task automatic test_pause();
        int pulses;
        do_reset();
        isRun     = 1'b0;
        isRender1 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (isCollide === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || hp !== 8'd20) begin
            errors++;
            $display("FAIL pause_no_hit: pulses=%0d hp=%0d, want pulses=0 hp=20", pulses, hp);
        end
        isRun = 1'b1;
        tick(1);
        checks++;
        if (isCollide !== 1'b0) begin
            errors++;
            $display("FAIL resume_latency1: col=%b, want 0", isCollide);
        end
        isRender1 = 1'b0;
        tick(1);
        checks++;
        if (isCollide !== 1'b1 || hp !== 8'd16) begin
            errors++;
            $display("FAIL resume_hit: col=%b hp=%0d, want col=1 hp=16", isCollide, hp);
        end
        // Counter holds while paused.
        isRun = 1'b0;
        tick(150);
        checks++;
        if (isInvincible !== 1'b1 || hp !== 8'd16) begin
            errors++;
            $display("FAIL pause_hold_inv: inv=%b hp=%0d, want inv=1 hp=16", isInvincible, hp);
        end
        isRun = 1'b1;
    endtask

    task automatic test_death();
        logic [7:0] seq_hp[5];
        logic [7:0] exp_seq[5];
        int n, pulses;
        exp_seq = '{8'd14, 8'd10, 8'd6, 8'd2, 8'd0};
        n = 0;
        do_reset();
        isRender1 = 1'b1;
        tick(1);
        isRender1 = 1'b0;
        color1    = 3'b001;
        tick(1);
        isRender1 = 1'b1;
        tick(1);
        isRender1 = 1'b0;
        tick(1);
        checks++;
        if (hp !== 8'd18) begin
            errors++;
            $display("FAIL death_setup: hp=%0d, want 18", hp);
        end
        color1    = 3'b000;
        isRender1 = 1'b1;
        for (int i = 0; i < 700 && isDead !== 1'b1; i++) begin
            tick(1);
            if (isCollide === 1'b1) begin
                if (n < 5) seq_hp[n] = hp;
                n++;
            end
        end
        checks++;
        if (n !== 5 || isDead !== 1'b1 || hp !== 8'd0) begin
            errors++;
            $display("FAIL death_reach: hits=%0d dead=%b hp=%0d, want hits=5 dead=1 hp=0",
                     n, isDead, hp);
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (seq_hp[j] !== exp_seq[j]) begin
                    errors++;
                    $display("FAIL death_seq%0d: hp=%0d, want %0d", j, seq_hp[j], exp_seq[j]);
                end
            end
        end
        // Dead: nothing moves, even with green and white overlapping for a long time.
        color2    = 3'b001;
        position2 = {8'd100, 8'd100};
        isRender2 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 250; i++) begin
            tick(1);
            if (isCollide === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || hp !== 8'd0 || isDead !== 1'b1) begin
            errors++;
            $display("FAIL dead_frozen: pulses=%0d hp=%0d dead=%b, want pulses=0 hp=0 dead=1",
                     pulses, hp, isDead);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (hp !== 8'd20 || isDead !== 1'b0 || isInvincible !== 1'b0 || isCollide !== 1'b0) begin
            errors++;
            $display("FAIL reset_from_dead: hp=%0d dead=%b inv=%b col=%b, want 20 0 0 0",
                     hp, isDead, isInvincible, isCollide);
        end
        isRender1 = 1'b0;
        isRender2 = 1'b0;
        color2    = 3'b000;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_pending();
        int pulses;
        do_reset();
        isRender1 = 1'b1;
        tick(1);
        isRender1 = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (hp !== 8'd20 || isCollide !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: hp=%0d col=%b, want hp=20 col=0", hp, isCollide);
        end
        tick(1);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (isCollide === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || hp !== 8'd20) begin
            errors++;
            $display("FAIL reset_no_pending: pulses=%0d hp=%0d, want pulses=0 hp=20", pulses, hp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        isRun = 1'b0;
        test_reset();
        test_single_hit();
        test_held_white();
        test_dual_and_heal();
        test_blue();
        test_pause();
        test_death();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
